pattern_machine: RTL and testbench

PATTERN_MACHINE -- requirements
Module: pattern_machine

---
 rtl/pattern_machine_pkg.sv | 19 +
 rtl/pm_next_state.sv | 62 ++++++
 rtl/pattern_machine.sv | 56 +++++
 tb/tb_pattern_machine.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/pattern_machine_pkg.sv
// Shared constants and helpers for the serial pattern matcher.
// Default geometry: 4-bit pattern 1011, 8-bit match counter.
package pattern_machine_pkg;

  localparam int DEF_PAT_W = 4;
  localparam int DEF_CNT_W = 8;
  localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 4'b1011;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pm_next_state.sv
// Combinational prefix-function transition for the pattern matcher.
// Zero latency; pure function of (s, x), no flow control.
module pm_next_state
  import pattern_machine_pkg::*;
#(
  parameter int                PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0]  PATTERN = DEF_PATTERN,
  parameter bit                OVERLAP = 1'b1,
  parameter int                SW      = clog2(DEF_PAT_W + 1)
) (
  input  logic [SW-1:0] s,
  input  logic          x,
  output logic [SW-1:0] s_nxt
);

  // Build the string "matched prefix + new bit" and find the longest
  // pattern prefix that is also its suffix; a full match is followed by
  // the failure length, or by a fresh start when overlap is disabled.
  function automatic int step(input int cur, input logic xb);
    logic [PAT_W:0]   t;
    logic [PAT_W:0]   sh;
    logic [PAT_W-1:0] pp;
    int               base;
    int               len;
    int               best;
    logic             ok;
    base = (cur == PAT_W && OVERLAP == 1'b0) ? 0 : cur;
    t    = '0;
    for (int j = 0; j <= PAT_W; j++) begin
      if (j < base) begin
        pp   = PATTERN >> (PAT_W - 1 - j);
        t[j] = pp[0];
      end else if (j == base) begin
        t[j] = xb;
      end
    end
    len  = base + 1;
    best = 0;
    for (int k = 1; k <= PAT_W; k++) begin
      if (k <= len) begin
        ok = 1'b1;
        for (int i = 0; i < PAT_W; i++) begin
          if (i < k) begin
            pp = PATTERN >> (PAT_W - 1 - i);
            sh = t >> (len - k + i);
            if (pp[0] != sh[0]) ok = 1'b0;
          end
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  always_comb begin
    s_nxt = '0;
    for (int c = 0; c <= PAT_W; c++) begin
      if (int'(s) == c) s_nxt = SW'(step(c, x));
    end
  end

endmodule

// File: rtl/pattern_machine.sv
// Serial pattern detector: S = matched prefix length, F = full match, optional counter.
// One cycle per consumed bit; en=0 holds all state. Counter built only with PATTERN_MACHINE_COUNT_EN.
module pattern_machine
  import pattern_machine_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = DEF_CNT_W
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          x,
  input  logic                          en,
  output logic                          F,
  output logic [clog2(PAT_W + 1)-1:0]   S,
  output logic [CNT_W-1:0]              match_cnt
);

  localparam int SW = clog2(PAT_W + 1);

  logic [SW-1:0] s_nxt;

  pm_next_state #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN),
    .OVERLAP (OVERLAP),
    .SW      (SW)
  ) u_next (
    .s     (S),
    .x     (x),
    .s_nxt (s_nxt)
  );

  always_ff @(posedge CLK) begin
    if (RESET) S <= '0;
    else if (en) S <= s_nxt;
  end

  assign F = (S == SW'(PAT_W));

`ifdef PATTERN_MACHINE_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturates at all-ones rather than wrapping.
  always_ff @(posedge CLK) begin
    if (RESET) cnt_q <= '0;
    else if (en && s_nxt == SW'(PAT_W) && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_pattern_machine.sv
// Randomized self-checking bench for pattern_machine against a history-based model.
module tb_pattern_machine;

  logic CLK = 1'b0;
  logic RESET, x, en;
  always #5 CLK = ~CLK;

  logic [2:0] so [4];
  logic       fo [4];
  logic [7:0] co [4];
  logic [1:0] c2;
  assign co[2] = {6'd0, c2};

  pattern_machine #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) d0 (
    .CLK(CLK), .RESET(RESET), .x(x), .en(en), .F(fo[0]), .S(so[0]), .match_cnt(co[0]));
  pattern_machine #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) d1 (
    .CLK(CLK), .RESET(RESET), .x(x), .en(en), .F(fo[1]), .S(so[1]), .match_cnt(co[1]));
  pattern_machine #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) d2 (
    .CLK(CLK), .RESET(RESET), .x(x), .en(en), .F(fo[2]), .S(so[2]), .match_cnt(c2));
  pattern_machine #(.PAT_W(5), .PATTERN(5'b11011), .OVERLAP(1'b1), .CNT_W(8)) d3 (
    .CLK(CLK), .RESET(RESET), .x(x), .en(en), .F(fo[3]), .S(so[3]), .match_cnt(co[3]));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: remember bits consumed since the last restart; S is the longest
  // pattern prefix equal to the tail of that history.
  int          w    [4] = '{4, 4, 4, 5};
  int unsigned pat  [4] = '{11, 11, 11, 27};
  bit          ov   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  int          cmax [4] = '{255, 255, 3, 255};
  int unsigned m_hist [4];
  int          m_len  [4];
  int          m_s    [4];
  int          m_cnt  [4];

  function automatic int longest(input int unsigned hist, input int len, input int pw, input int unsigned p);
    int best;
    best = 0;
    for (int k = 1; k <= pw; k++) begin
      if (k <= len && (hist & ((32'd1 << k) - 1)) == (p >> (pw - k))) best = k;
    end
    return best;
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 4; i++) begin
      if (RESET) begin
        m_hist[i] = 0; m_len[i] = 0; m_s[i] = 0; m_cnt[i] = 0;
      end else if (en) begin
        if (!ov[i] && m_s[i] == w[i]) begin
          m_hist[i] = 0; m_len[i] = 0;
        end
        m_hist[i] = (m_hist[i] << 1) | 32'(x);
        if (m_len[i] < 31) m_len[i]++;
        m_s[i] = longest(m_hist[i], m_len[i], w[i], pat[i]);
        if (m_s[i] == w[i] && m_cnt[i] < cmax[i]) m_cnt[i]++;
      end
    end
  endtask

  function automatic int exp_cnt(input int i);
`ifdef PATTERN_MACHINE_COUNT_EN
    return m_cnt[i];
`else
    return 0 * i;
`endif
  endfunction

  task automatic apply(input logic rst, input logic e, input logic xb);
    RESET = rst; en = e; x = xb;
    @(posedge CLK);
    model_edge();
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("S[%0d]", i), 32'(so[i]), 32'(m_s[i]));
      chk($sformatf("F[%0d]", i), 32'(fo[i]), 32'(m_s[i] == w[i]));
      chk($sformatf("cnt[%0d]", i), 32'(co[i]), 32'(exp_cnt(i)));
    end
  endtask

  logic [6:0] stream;
  int ov_s  [7] = '{1, 2, 3, 4, 2, 3, 4};
  int nov_s [7] = '{1, 2, 3, 4, 0, 1, 1};
  int sat_e [5] = '{1, 2, 3, 3, 3};
  logic [15:0] sat_stream;

  initial begin
    RESET = 1'b1; en = 1'b0; x = 1'b0;

    // Reset for two edges with x toggling.
    apply(1'b1, 1'b1, 1'b0);
    apply(1'b1, 1'b1, 1'b1);
    chk("rst_S", 32'(so[0]), 0);
    chk("rst_F", 32'(fo[0]), 0);
    chk("rst_cnt", 32'(co[0]), 0);

    // Basic match followed by overlap / non-overlap continuation.
    stream = 7'b1011011;
    for (int i = 0; i < 7; i++) begin
      apply(1'b0, 1'b1, stream[6-i]);
      chk($sformatf("ovl_S%0d", i), 32'(so[0]), 32'(ov_s[i]));
      chk($sformatf("nov_S%0d", i), 32'(so[1]), 32'(nov_s[i]));
      chk($sformatf("ovl_F%0d", i), 32'(fo[0]), 32'(i == 3 || i == 6));
      chk($sformatf("nov_F%0d", i), 32'(fo[1]), 32'(i == 3));
    end
`ifdef PATTERN_MACHINE_COUNT_EN
    chk("ovl_cnt", 32'(co[0]), 2);
    chk("nov_cnt", 32'(co[1]), 1);
`else
    chk("ovl_cnt", 32'(co[0]), 0);
    chk("nov_cnt", 32'(co[1]), 0);
`endif

    // Enable hold and mid-pattern reset.
    apply(1'b1, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b1);
    apply(1'b0, 1'b1, 1'b0);
    apply(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, 1'(i));
      chk("hold_S", 32'(so[0]), 3);
    end
    apply(1'b1, 1'b1, 1'b1);
    chk("midrst_S", 32'(so[0]), 0);
    apply(1'b0, 1'b1, 1'b1);
    chk("after_rst_S", 32'(so[0]), 1);
    chk("after_rst_F", 32'(fo[0]), 0);

    // Counter saturation on the 2-bit instance: five overlapping matches.
    apply(1'b1, 1'b0, 1'b0);
    sat_stream = 16'b1011011011011011;
    for (int i = 0; i < 16; i++) begin
      apply(1'b0, 1'b1, sat_stream[15-i]);
      if (i >= 3 && (i - 3) % 3 == 0) begin
`ifdef PATTERN_MACHINE_COUNT_EN
        chk($sformatf("sat%0d", (i - 3) / 3), 32'(c2), 32'(sat_e[(i - 3) / 3]));
`else
        chk($sformatf("sat%0d", (i - 3) / 3), 32'(c2), 0);
`endif
      end
    end

    // Randomized traffic with occasional reset and enable gaps.
    for (int n = 0; n < 3000; n++) begin
      apply(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 8), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
